// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: issues one bus request per aligned load/store,
// extends load data, flags misaligned accesses and forwards results to EX.
module mem_access_stage #(
  parameter int PAYLOAD_W = 64,
  parameter bit ALE_EN    = 1'b1,
  parameter int DW        = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 flush,
  input  logic                 in_mem,
  input  logic                 in_store,
  input  logic [1:0]           in_size,
  input  logic                 in_uns,
  input  logic [31:0]          in_addr,
  input  logic [DW-1:0]        in_wdata,
  input  logic [4:0]           in_rd,
  input  logic                 in_gr_we,
  input  logic [PAYLOAD_W-1:0] in_side,
  output logic                 req,
  output logic                 wr,
  output logic [1:0]           size,
  output logic [DW/8-1:0]      wstrb,
  output logic [31:0]          addr,
  output logic [DW-1:0]        wdata,
  input  logic                 addr_ok,
  input  logic                 data_ok,
  input  logic [DW-1:0]        rdata,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4:0]           out_rd,
  output logic                 out_gr_we,
  output logic [DW-1:0]        out_data,
  output logic [PAYLOAD_W-1:0] out_side,
  output logic                 out_ale,
  output logic                 fwd_valid,
  output logic [4:0]           fwd_rd,
  output logic [DW-1:0]        fwd_data,
  output logic                 fwd_busy
);
  // state | meaning
  // IDLE  | no instruction held
  // REQ   | bus request asserted, waiting for addr_ok
  // WAIT  | address accepted, waiting for data_ok
  // HOLD  | result ready, presenting to WB
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

  localparam int BW = DW / 8;
  localparam int LW = $clog2(BW);

  state_t                state_q, state_d;
  logic                  cancel_q, cancel_d;
  logic                  mem_q, store_q, uns_q, gr_we_q, ale_q;
  logic [1:0]            size_q;
  logic [31:0]           addr_q;
  logic [DW-1:0]         wdata_q, result_q;
  logic [4:0]            rd_q;
  logic [PAYLOAD_W-1:0]  side_q;

  logic                  accept, capture_ld;
  logic [1:0]            in_size_eff;
  logic                  in_mis, in_ale;
  logic [DW-1:0]         alu_val, ld_val, shifted, mask;
  logic                  sgn;
  logic [LW-1:0]         off;
  logic [BW-1:0]         strb_base;

  // On a 32-bit datapath a doubleword request degenerates to a word
  always_comb begin
    in_size_eff = (DW == 32 && in_size == 2'd3) ? 2'd2 : in_size;
    case (in_size_eff)
      2'd1:    in_mis = in_addr[0];
      2'd2:    in_mis = |in_addr[1:0];
      2'd3:    in_mis = |in_addr[2:0];
      default: in_mis = 1'b0;
    endcase
    in_ale = ALE_EN && in_mem && in_mis;
    alu_val = '0;
    alu_val[31:0] = in_addr;
  end

  always_comb begin
    state_d    = state_q;
    cancel_d   = cancel_q;
    accept     = 1'b0;
    capture_ld = 1'b0;
    in_ready   = (state_q == S_IDLE) || ((state_q == S_HOLD) && out_ready);
    case (state_q)
      S_IDLE: begin
        if (!flush && in_valid) accept = 1'b1;
      end
      S_REQ: begin
        if (addr_ok && data_ok) begin
          state_d    = (cancel_q || flush) ? S_IDLE : S_HOLD;
          capture_ld = !(cancel_q || flush);
          cancel_d   = 1'b0;
        end else begin
          if (addr_ok) state_d = S_WAIT;
          cancel_d = cancel_q || flush;
        end
      end
      S_WAIT: begin
        if (data_ok) begin
          state_d    = (cancel_q || flush) ? S_IDLE : S_HOLD;
          capture_ld = !(cancel_q || flush);
          cancel_d   = 1'b0;
        end else begin
          cancel_d = cancel_q || flush;
        end
      end
      S_HOLD: begin
        if (flush) state_d = S_IDLE;
        else if (out_ready) begin
          if (in_valid) accept = 1'b1;
          else state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (accept) begin
      state_d  = (in_mem && !in_ale) ? S_REQ : S_HOLD;
      cancel_d = 1'b0;
    end
  end

  // Load path: shift the addressed lane down, then mask and extend
  always_comb begin
    off     = addr_q[LW-1:0];
    shifted = rdata >> {off, 3'b000};
    mask    = '0;
    sgn     = 1'b0;
    case (size_q)
      2'd0:    begin mask[7:0]  = '1; sgn = shifted[7];  end
      2'd1:    begin mask[15:0] = '1; sgn = shifted[15]; end
      2'd2:    begin mask[31:0] = '1; sgn = shifted[31]; end
      default: mask = '1;
    endcase
    ld_val = (shifted & mask) | ({DW{sgn & ~uns_q}} & ~mask);
  end

  always_comb begin
    strb_base = '0;
    case (size_q)
      2'd0:    begin strb_base[0] = 1'b1; wdata = {BW{wdata_q[7:0]}}; end
      2'd1:    begin strb_base[1:0] = '1; wdata = {(DW/16){wdata_q[15:0]}}; end
      2'd2:    begin strb_base[3:0] = '1; wdata = {(DW/32){wdata_q[31:0]}}; end
      default: begin strb_base = '1; wdata = wdata_q; end
    endcase
  end

  assign req       = (state_q == S_REQ);
  assign wr        = req && store_q;
  assign wstrb     = wr ? (strb_base << off) : '0;
  assign size      = size_q;
  assign addr      = addr_q;
  assign out_valid = (state_q == S_HOLD);
  assign out_rd    = rd_q;
  assign out_gr_we = gr_we_q && !ale_q;
  assign out_data  = result_q;
  assign out_side  = side_q;
  assign out_ale   = out_valid && ale_q;
  assign fwd_valid = (state_q != S_IDLE) && gr_we_q && !ale_q;
  assign fwd_rd    = rd_q;
  assign fwd_data  = result_q;
  assign fwd_busy  = mem_q && !store_q && ((state_q == S_REQ) || (state_q == S_WAIT));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cancel_q <= 1'b0;
      mem_q    <= 1'b0;
      store_q  <= 1'b0;
      uns_q    <= 1'b0;
      gr_we_q  <= 1'b0;
      ale_q    <= 1'b0;
      size_q   <= 2'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_q     <= '0;
      side_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cancel_q <= cancel_d;
      if (accept) begin
        mem_q    <= in_mem;
        store_q  <= in_store;
        uns_q    <= in_uns;
        gr_we_q  <= in_gr_we;
        ale_q    <= in_ale;
        size_q   <= in_size_eff;
        addr_q   <= in_addr;
        wdata_q  <= in_wdata;
        rd_q     <= in_rd;
        side_q   <= in_side;
        result_q <= alu_val;
      end else if (capture_ld) begin
        result_q <= ld_val;
      end
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage with directed bus responses.
module tb_mem_access_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, flush;
  logic        in_mem, in_store, in_uns, in_gr_we;
  logic [1:0]  in_size;
  logic [31:0] in_addr, in_wdata;
  logic [4:0]  in_rd;
  logic [63:0] in_side;
  logic        req, wr, addr_ok, data_ok;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr, wdata, rdata;
  logic        out_valid, out_ready, out_gr_we, out_ale;
  logic [4:0]  out_rd;
  logic [31:0] out_data;
  logic [63:0] out_side;
  logic        fwd_valid, fwd_busy;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  rd;
    logic        gr_we;
    logic [31:0] data;
    logic        ale;
    bit          chk_data;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  mem_access_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .in_mem(in_mem), .in_store(in_store), .in_size(in_size), .in_uns(in_uns),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd), .in_gr_we(in_gr_we),
    .in_side(in_side), .req(req), .wr(wr), .size(size), .wstrb(wstrb), .addr(addr),
    .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd), .out_gr_we(out_gr_we),
    .out_data(out_data), .out_side(out_side), .out_ale(out_ale), .fwd_valid(fwd_valid),
    .fwd_rd(fwd_rd), .fwd_data(fwd_data), .fwd_busy(fwd_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic expect_out(input logic [4:0] rd, input logic we, input logic [31:0] d,
                            input logic ale, input bit chkd);
    exp_t e;
    e.rd = rd; e.gr_we = we; e.data = d; e.ale = ale; e.chk_data = chkd;
    sb.push_back(e);
  endtask

  task automatic issue(input logic mem, input logic st, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                       input logic we);
    bit ok;
    in_valid = 1'b1; in_mem = mem; in_store = st; in_size = sz; in_uns = uns;
    in_addr = a; in_wdata = wd; in_rd = rd; in_gr_we = we; in_side = {a, wd};
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      smp();
      if (in_ready) ok = 1'b1;
      else step();
    end
    if (!ok) check("issue_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) check("spurious_out_valid", out_valid, 0);
      else begin
        mon_e = sb.pop_front();
        check("out_rd", out_rd, mon_e.rd);
        check("out_gr_we", out_gr_we, mon_e.gr_we);
        check("out_ale", out_ale, mon_e.ale);
        if (mon_e.chk_data) check("out_data", out_data, mon_e.data);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  logic [1:0]  f_sz[5]  = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd3};
  logic        f_uns[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [31:0] f_a[5]   = '{32'h21, 32'h22, 32'h24, 32'h20, 32'h28};
  logic [31:0] f_rd[5]  = '{32'h0000_9900, 32'h8001_0000, 32'h8765_4321, 32'h0000_007F, 32'h1122_3344};
  logic [31:0] f_ex[5]  = '{32'h0000_0099, 32'hFFFF_8001, 32'h8765_4321, 32'h0000_007F, 32'h1122_3344};

  initial begin
    rst = 1'b1; in_valid = 0; flush = 0; in_mem = 0; in_store = 0; in_size = 0; in_uns = 0;
    in_addr = 0; in_wdata = 0; in_rd = 0; in_gr_we = 0; in_side = 0;
    addr_ok = 0; data_ok = 0; rdata = 0; out_ready = 1;
    @(posedge clk); @(posedge clk);
    smp();
    check("rst_req", req, 0); check("rst_wstrb", wstrb, 0); check("rst_out_valid", out_valid, 0);
    check("rst_out_ale", out_ale, 0); check("rst_fwd_valid", fwd_valid, 0);
    check("rst_fwd_busy", fwd_busy, 0); check("rst_out_data", out_data, 0);
    step(); rst = 1'b0;
    smp(); check("rst_in_ready", in_ready, 1);
    step();

    // ld.b signed, addr_ok after one cycle, data_ok later
    expect_out(5'd5, 1'b1, 32'hFFFF_FF80, 1'b0, 1'b1);
    issue(1, 0, 2'd0, 0, 32'h1003, 0, 5'd5, 1);
    smp(); check("ldb_req", req, 1); check("ldb_wr", wr, 0); check("ldb_addr", addr, 32'h1003);
    check("ldb_size", size, 0); check("ldb_busy", fwd_busy, 1); check("ldb_in_ready", in_ready, 0);
    step(); addr_ok = 1;
    smp(); check("ldb_req_hold", req, 1);
    step(); addr_ok = 0;
    smp(); check("ldb_req_once", req, 0); check("ldb_busy_wait", fwd_busy, 1);
    step(); data_ok = 1; rdata = 32'h80AA_BBCC;
    smp(); check("ldb_valid_early", out_valid, 0);
    step(); data_ok = 0;
    smp(); check("ldb_valid_lat", out_valid, 1);
    step();

    // st.h with addr_ok withheld for three cycles
    expect_out(5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
    issue(1, 1, 2'd1, 0, 32'h2002, 32'h1234, 5'd0, 0);
    for (int i = 0; i < 3; i++) begin
      smp(); check("sth_req", req, 1); check("sth_wr", wr, 1); check("sth_wstrb", wstrb, 4'b1100);
      check("sth_wdata", wdata, 32'h1234_1234); check("sth_addr", addr, 32'h2002);
      step();
    end
    addr_ok = 1;
    smp(); step(); addr_ok = 0;
    smp(); check("sth_req_drop", req, 0); check("sth_wstrb_idle", wstrb, 0); check("sth_wait", out_valid, 0);
    step(); data_ok = 1;
    smp(); step(); data_ok = 0;
    smp(); check("sth_valid", out_valid, 1);
    step();

    // misaligned ld.w
    expect_out(5'd7, 1'b0, 32'h0, 1'b1, 1'b0);
    issue(1, 0, 2'd2, 0, 32'h3001, 0, 5'd7, 1);
    smp(); check("ale_req", req, 0); check("ale_valid", out_valid, 1); check("ale_flag", out_ale, 1);
    check("ale_gr_we", out_gr_we, 0); check("ale_fwd_valid", fwd_valid, 0);
    step();

    // flush during WAIT, data_ok two cycles later is discarded
    issue(1, 0, 2'd2, 0, 32'h4000, 0, 5'd3, 1);
    step(); addr_ok = 1;
    step(); addr_ok = 0; flush = 1;
    step(); flush = 0;
    smp(); check("flw_in_ready", in_ready, 0);
    step(); data_ok = 1; rdata = 32'hDEAD_BEEF;
    smp(); check("flw_in_ready_dok", in_ready, 0);
    step(); data_ok = 0;
    smp(); check("flw_in_ready_after", in_ready, 1); check("flw_no_valid", out_valid, 0);
    step();

    // ALU op stalled by WB
    out_ready = 0;
    expect_out(5'd9, 1'b1, 32'hCAFE_0010, 1'b0, 1'b1);
    issue(0, 0, 2'd0, 0, 32'hCAFE_0010, 0, 5'd9, 1);
    for (int i = 0; i < 4; i++) begin
      smp(); check("alu_valid", out_valid, 1); check("alu_in_ready", in_ready, 0);
      check("alu_fwd_valid", fwd_valid, 1); check("alu_fwd_data", fwd_data, 32'hCAFE_0010);
      check("alu_fwd_rd", fwd_rd, 9); check("alu_fwd_busy", fwd_busy, 0);
      step();
    end
    out_ready = 1;
    smp(); step();
    smp(); check("alu_released", out_valid, 0);
    step();

    // back-to-back ALU ops accepted from HOLD
    expect_out(5'd1, 1'b1, 32'h0000_0111, 1'b0, 1'b1);
    expect_out(5'd2, 1'b1, 32'h0000_0222, 1'b0, 1'b1);
    issue(0, 0, 2'd0, 0, 32'h111, 0, 5'd1, 1);
    issue(0, 0, 2'd0, 0, 32'h222, 0, 5'd2, 1);
    smp(); step();

    // ld.hu with addr_ok and data_ok together
    expect_out(5'd11, 1'b1, 32'h0000_F00D, 1'b0, 1'b1);
    issue(1, 0, 2'd1, 1, 32'h10, 0, 5'd11, 1);
    smp(); check("lhu_req", req, 1);
    step(); addr_ok = 1; data_ok = 1; rdata = 32'h0000_F00D;
    smp(); step(); addr_ok = 0; data_ok = 0;
    smp(); check("lhu_skip_wait", out_valid, 1); check("lhu_req_drop", req, 0);
    step();

    // extension table, same-cycle responses
    for (int k = 0; k < 5; k++) begin
      expect_out(5'd20 + 5'(k), 1'b1, f_ex[k], 1'b0, 1'b1);
      issue(1, 0, f_sz[k], f_uns[k], f_a[k], 0, 5'd20 + 5'(k), 1);
      addr_ok = 1; data_ok = 1; rdata = f_rd[k];
      step(); addr_ok = 0; data_ok = 0;
      smp(); check("tbl_valid", out_valid, 1);
      step();
    end

    // flush while in REQ: request must stay up until addr_ok
    issue(1, 0, 2'd2, 0, 32'h50, 0, 5'd4, 1);
    flush = 1;
    step(); flush = 0;
    smp(); check("flr_req_kept", req, 1);
    step();
    smp(); check("flr_req_kept2", req, 1);
    step(); addr_ok = 1;
    smp(); step(); addr_ok = 0; data_ok = 1; rdata = 32'h1;
    smp(); check("flr_in_ready_dok", in_ready, 0);
    step(); data_ok = 0;
    smp(); check("flr_no_valid", out_valid, 0); check("flr_in_ready", in_ready, 1);
    step();

    // reset mid-transaction, late data_ok ignored
    issue(1, 0, 2'd2, 0, 32'h60, 0, 5'd6, 1);
    rst = 1;
    step(); rst = 0; data_ok = 1; rdata = 32'h5;
    smp(); check("rmid_req", req, 0); check("rmid_in_ready", in_ready, 1);
    step(); data_ok = 0;
    smp(); check("rmid_no_valid", out_valid, 0); check("rmid_fwd_busy", fwd_busy, 0);
    step();

    repeat (3) step();
    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have parameter PAYLOAD_W, default 64, width of opaque sideband (pc, IR) carried to WB.
REQ-002 SHALL have parameter ALE_EN, default 1, enables misaligned-access detection.
REQ-003 SHALL have parameter DW, default 32, data width; legal values 32 and 64.
REQ-004 Ports: clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-005 Ports: in_valid in 1 EX payload valid; in_ready out 1 stage accepts; flush in 1 cancel in-flight instruction.
REQ-006 Ports: in_mem in 1 memory op; in_store in 1 store; in_size in 2 (0=b,1=h,2=w,3=d); in_uns in 1 zero-extend load.
REQ-007 Ports: in_addr in 32 address/ALU result; in_wdata in DW store data; in_rd in 5 dest reg; in_gr_we in 1 reg write; in_side in PAYLOAD_W sideband.
REQ-008 Ports: req out 1; wr out 1; size out 2; wstrb out DW/8; addr out 32; wdata out DW; addr_ok in 1; data_ok in 1; rdata in DW.
REQ-009 Ports: out_valid out 1; out_ready in 1; out_rd out 5; out_gr_we out 1; out_data out DW; out_side out PAYLOAD_W; out_ale out 1.
REQ-010 Ports: fwd_valid out 1; fwd_rd out 5; fwd_data out DW; fwd_busy out 1 (dest value not yet available).

Function
REQ-011 SHALL use FSM IDLE, REQ, WAIT, HOLD; IDLE = no instruction held.
REQ-012 in_ready SHALL be 1 in IDLE, or in HOLD with out_ready=1; 0 otherwise; fields captured on in_valid & in_ready.
REQ-013 Non-memory or misaligned op (ALE_EN=1; h: addr[0]!=0, w: addr[1:0]!=0, d: addr[2:0]!=0) SHALL go directly to HOLD, issue no bus request; misaligned sets out_ale=1, out_gr_we=0.
REQ-014 Aligned memory op SHALL enter REQ; req=1 held, all bus fields stable, until addr_ok; then WAIT; if addr_ok and data_ok same cycle, HOLD directly.
REQ-015 In WAIT, data_ok SHALL capture extended rdata into result register and enter HOLD; stores also wait for data_ok.
REQ-016 Load extension: lane = addr[log2(DW/8)-1:size]; selected byte/half/word sign- or zero-extended per in_uns to DW; size 3 only when DW=64, else treated as word.
REQ-017 wstrb: one-hot byte per lane for b, 2-bit per half-lane, 4-bit per word-lane, all ones for d; zero when wr=0; wdata = replicated low bytes of in_wdata.
REQ-018 out_valid SHALL equal (state==HOLD); HOLD exits to IDLE on out_ready, or to next instruction state if in_valid same cycle.
REQ-019 flush in IDLE/HOLD SHALL drop held instruction, state IDLE, out_valid=0 next cycle.
REQ-020 flush in REQ SHALL keep req asserted until addr_ok (no withdrawal), then set cancel flag; flush in WAIT sets cancel flag.
REQ-021 With cancel set, the matching data_ok SHALL be discarded, state IDLE, no out_valid; in_ready stays 0 until discard.
REQ-022 fwd_valid = held instruction with in_gr_we & ~ale; fwd_data = ALU value for non-loads, loaded value in HOLD; fwd_busy=1 for loads in REQ/WAIT.
REQ-023 Exactly one bus request SHALL issue per aligned memory op; no new req until prior data_ok received.

Reset
REQ-024 On rst: state IDLE, cancel=0, req=0, wstrb=0, out_valid=0, out_ale=0, fwd_valid=0, fwd_busy=0, result/side registers 0; in_ready=1 cycle after.
REQ-025 rst mid-transaction SHALL abandon it; a late data_ok after reset SHALL be ignored in IDLE.

Verification
REQ-026 ld.b addr 0x1003, rdata 0x80AA_BBCC -> out_data 0xFFFF_FF80, out_valid one cycle after data_ok.
REQ-027 st.h addr 0x2002 data 0x1234 -> wstrb 4'b1100, wdata 0x1234_1234, req held 3 cycles while addr_ok=0.
REQ-028 ld.w addr 0x3001, ALE_EN=1 -> no req, out_ale=1, out_gr_we=0, out_valid next cycle.
REQ-029 ld.w issued, flush in WAIT, data_ok 2 cycles later -> no out_valid, in_ready returns 1 cycle after data_ok.
REQ-030 ALU op held with out_ready=0 for 4 cycles -> out_valid stays 1, in_ready=0, fwd_valid=1 with ALU value throughout.
REQ-031 ld.hu with addr_ok and data_ok same cycle, addr 0x10 rdata 0x0000_F00D -> out_data 0x0000_F00D, state skips WAIT.
